// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file: write-extension modes
// and default geometry.
package reg_file_mp_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;

  localparam logic [2:0] WR_WORD   = 3'd0;
  localparam logic [2:0] WR_HALF_Z = 3'd1;
  localparam logic [2:0] WR_BYTE_Z = 3'd2;
  localparam logic [2:0] WR_HALF_S = 3'd3;
  localparam logic [2:0] WR_BYTE_S = 3'd4;

endpackage

// File: rtl/reg_wr_ext.sv
// Combinational write-data extender. Shared by the array write and the
// read bypass so both always see the same extended value.
module reg_wr_ext
  import reg_file_mp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [2:0]       wr_mode_i,
  output logic [WIDTH-1:0] ext_data_o,
  output logic             mode_ok_o
);

  always_comb begin
    ext_data_o = '0;
    mode_ok_o  = 1'b1;
    case (wr_mode_i)
      WR_WORD:   ext_data_o = wr_data_i;
      WR_HALF_Z: ext_data_o = WIDTH'(wr_data_i[15:0]);
      WR_BYTE_Z: ext_data_o = WIDTH'(wr_data_i[7:0]);
      // Size cast of a signed operand replicates its top bit.
      WR_HALF_S: ext_data_o = WIDTH'($signed(wr_data_i[15:0]));
      WR_BYTE_S: ext_data_o = WIDTH'($signed(wr_data_i[7:0]));
      default:   mode_ok_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with registered reads, write-to-read
// bypass, extending partial writes and a per-register busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_LEN = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_LEN-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]    rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_LEN-1:0]        wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [2:0]                 wr_mode,
  output logic                       wr_err,
  input  logic                       rsv_en,
  input  logic [ADDR_LEN-1:0]        rsv_addr
);

  // Read handshake: there is no ready. Every rd_en[i] sampled at an edge is
  // accepted and answered by rd_valid[i] for exactly one cycle after it.

  logic [WIDTH-1:0]        regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]     busy_q, busy_d;
  logic [NUM_RD*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]       rd_busy_q, rd_busy_d;
  logic [NUM_RD-1:0]       rd_valid_q;
  logic                    wr_err_q;

  logic [WIDTH-1:0]    ext_data;
  logic                mode_ok;
  logic                wr_legal;
  logic                wr_do;
  logic [ADDR_LEN-1:0] rd_addr_w [NUM_RD];

  reg_wr_ext #(.WIDTH(WIDTH)) u_ext (
    .wr_data_i  (wr_data),
    .wr_mode_i  (wr_mode),
    .ext_data_o (ext_data),
    .mode_ok_o  (mode_ok)
  );

  assign wr_legal = wr_en & mode_ok;
  assign wr_do    = wr_legal & (wr_addr != '0);

  for (genvar g = 0; g < NUM_RD; g++) begin : g_addr
    assign rd_addr_w[g] = rd_addr[g*ADDR_LEN +: ADDR_LEN];
  end

  // Reserve is applied after the clear: a same-edge reserve marks a younger
  // producer and must win over the completing write.
  always_comb begin
    busy_d = busy_q;
    if (wr_legal) busy_d[wr_addr] = 1'b0;
    if (rsv_en)   busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_en[i]) begin
        if (rd_addr_w[i] == '0) begin
          rd_data_d[i*WIDTH +: WIDTH] = '0;
          rd_busy_d[i]                = 1'b0;
        end else begin
          if (wr_do && (wr_addr == rd_addr_w[i]))
            rd_data_d[i*WIDTH +: WIDTH] = ext_data;
          else
            rd_data_d[i*WIDTH +: WIDTH] = regs_q[rd_addr_w[i]];
          rd_busy_d[i] = busy_q[rd_addr_w[i]] &
                         ~(wr_legal && (wr_addr == rd_addr_w[i]));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (wr_do) begin
      regs_q[wr_addr] <= ext_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      rd_valid_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
      rd_valid_q <= rd_en;
      wr_err_q   <= wr_en & ~mode_ok;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign rd_valid = rd_valid_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp at WIDTH=64, NUM_RD=4: directed steps
// plus a random burst, checked against a reference model and scoreboard.
module tb_reg_file_mp;

  localparam int W     = 64;
  localparam int NR    = 4;
  localparam int NREGS = 32;
  localparam int AL    = 5;
  localparam int EW    = W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rd_en;
  logic [NR*AL-1:0]  rd_addr;
  logic [NR*W-1:0]   rd_data;
  logic [NR-1:0]     rd_valid;
  logic [NR-1:0]     rd_busy;
  logic              wr_en;
  logic [AL-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [2:0]        wr_mode;
  logic              wr_err;
  logic              rsv_en;
  logic [AL-1:0]     rsv_addr;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0]     exp_q[$];
  logic [W-1:0]      mdl [NREGS];
  logic [NREGS-1:0]  mbusy;

  reg_file_mp #(.WIDTH(W), .NUM_REGS(NREGS), .NUM_RD(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mode  (wr_mode),
    .wr_err   (wr_err),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference extension
  function automatic logic [W-1:0] model_ext(input logic [W-1:0] d, input logic [2:0] m);
    case (m)
      3'd0:    return d;
      3'd1:    return {48'h0, d[15:0]};
      3'd2:    return {56'h0, d[7:0]};
      3'd3:    return {{48{d[15]}}, d[15:0]};
      3'd4:    return {{56{d[7]}}, d[7:0]};
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) mdl[r] = '0;
    mbusy = '0;
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic idle();
    rd_en = '0; rd_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 3'd0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AL-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AL +: AL] = a;
  endtask

  task automatic set_wr(input logic [AL-1:0] a, input logic [W-1:0] d, input logic [2:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mode = m;
  endtask

  task automatic set_rsv(input logic [AL-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  // One clock: predict from the model, clock, check, then advance the model.
  task automatic cycle();
    logic          legal;
    logic [W-1:0]  e;
    logic [W-1:0]  d;
    logic          b;
    logic [AL-1:0] a;
    logic [NR-1:0] en_s;
    logic          err_s;
    logic [EW-1:0] ent;
    legal = wr_en && (wr_mode <= 3'd4);
    e     = model_ext(wr_data, wr_mode);
    en_s  = rd_en;
    err_s = wr_en && !legal;
    for (int p = 0; p < NR; p++) begin
      if (en_s[p]) begin
        a = rd_addr[p*AL +: AL];
        if (a == 0) begin
          d = '0; b = 1'b0;
        end else begin
          d = (legal && wr_addr == a) ? e : mdl[a];
          b = mbusy[a] && !(legal && wr_addr == a);
        end
        exp_q.push_back({b, d});
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("valid_p%0d", p), W'(rd_valid[p]), W'(en_s[p]));
      if (en_s[p]) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 64'd1, 64'd0);
        end else begin
          ent = exp_q.pop_front();
          chk($sformatf("data_p%0d", p), rd_data[p*W +: W], ent[W-1:0]);
          chk($sformatf("busy_p%0d", p), W'(rd_busy[p]), W'(ent[W]));
        end
      end
    end
    chk("wr_err", W'(wr_err), W'(err_s));
    if (legal && wr_addr != 0) mdl[wr_addr] = e;
    if (legal) mbusy[wr_addr] = 1'b0;
    if (rsv_en) mbusy[rsv_addr] = 1'b1;
    mbusy[0] = 1'b0;
  endtask

  logic [2:0]   modes [4];
  logic [W-1:0] mexp  [4];

  initial begin
    modes[0] = 3'd3; mexp[0] = 64'hFFFF_FFFF_FFFF_80F0;
    modes[1] = 3'd1; mexp[1] = 64'h0000_0000_0000_80F0;
    modes[2] = 3'd4; mexp[2] = 64'hFFFF_FFFF_FFFF_FFF0;
    modes[3] = 3'd2; mexp[3] = 64'h0000_0000_0000_00F0;

    idle();
    model_reset();
    rst = 1'b1;
    #2;
    chk("rst_valid", W'(rd_valid), '0);
    chk("rst_data_lo", rd_data[W-1:0], '0);
    chk("rst_busy", W'(rd_busy), '0);
    chk("rst_err", W'(wr_err), '0);
    @(negedge clk);
    rst = 1'b0;

    // Word write and r0 read
    set_wr(5'd5, 64'hDEAD_BEEF, 3'd0); cycle(); idle();
    set_rd(0, 5'd5); set_rd(1, 5'd0); cycle();
    chk("r5_word", rd_data[0 +: W], 64'hDEAD_BEEF);
    chk("r0_port1", rd_data[W +: W], '0);
    chk("both_valid", W'(rd_valid[1:0]), 64'd3);
    idle();
    set_wr(5'd0, 64'h1234, 3'd0); cycle(); idle();
    set_rd(0, 5'd0); cycle();
    chk("r0_stays_zero", rd_data[0 +: W], '0);
    idle();

    // Extension modes on r7
    for (int k = 0; k < 4; k++) begin
      set_wr(5'd7, 64'h80F0, modes[k]); cycle(); idle();
      set_rd(0, 5'd7); cycle();
      chk($sformatf("r7_mode%0d", modes[k]), rd_data[0 +: W], mexp[k]);
      idle();
    end
    set_wr(5'd7, 64'h1234_5678, 3'd6); cycle();
    chk("illegal_err_hi", W'(wr_err), 64'd1);
    idle();
    set_rd(0, 5'd7); cycle();
    chk("illegal_err_lo", W'(wr_err), 64'd0);
    chk("r7_unchanged", rd_data[0 +: W], 64'hF0);
    idle();

    // Bypass on both ports
    set_wr(5'd3, 64'h99, 3'd0); cycle(); idle();
    set_wr(5'd3, 64'h11, 3'd0); set_rd(0, 5'd3); set_rd(1, 5'd3); cycle();
    chk("bypass_p0", rd_data[0 +: W], 64'h11);
    chk("bypass_p1", rd_data[W +: W], 64'h11);
    chk("bypass_busy", W'(rd_busy[1:0]), 64'd0);
    idle();

    // Busy scoreboard on r9 / r4
    set_rsv(5'd9); cycle(); idle();
    set_rd(0, 5'd9); cycle();
    chk("r9_busy_set", W'(rd_busy[0]), 64'd1);
    idle();
    set_rsv(5'd9); set_wr(5'd9, 64'h55, 3'd0); cycle(); idle();
    set_rd(0, 5'd9); cycle();
    chk("r9_rsv_wins", W'(rd_busy[0]), 64'd1);
    idle();
    set_wr(5'd9, 64'h66, 3'd0); set_rd(0, 5'd9); cycle();
    chk("r9_clear_same_edge", W'(rd_busy[0]), 64'd0);
    chk("r9_bypass_data", rd_data[0 +: W], 64'h66);
    idle();
    set_rsv(5'd4); set_rd(0, 5'd4); cycle();
    chk("r4_rsv_not_visible", W'(rd_busy[0]), 64'd0);
    idle();
    set_rd(0, 5'd4); cycle();
    chk("r4_busy_next", W'(rd_busy[0]), 64'd1);
    idle();

    // Random back-to-back reads on all ports
    for (int c = 0; c < 64; c++) begin
      idle();
      for (int p = 0; p < NR; p++) set_rd(p, AL'($urandom_range(0, NREGS-1)));
      if ($urandom_range(0, 3) != 0)
        set_wr(AL'($urandom_range(0, NREGS-1)), {$urandom, $urandom},
               3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) set_rsv(AL'($urandom_range(0, NREGS-1)));
      cycle();
    end

    // Reset in the middle of a read
    idle();
    for (int p = 0; p < NR; p++) set_rd(p, AL'(p + 5));
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", W'(rd_valid), '0);
    for (int p = 0; p < NR; p++) chk($sformatf("midrst_data_p%0d", p), rd_data[p*W +: W], '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    cycle();
    for (int base = 0; base < NREGS; base += NR) begin
      idle();
      for (int p = 0; p < NR; p++) set_rd(p, AL'(base + p));
      cycle();
      for (int p = 0; p < NR; p++)
        chk($sformatf("post_rst_r%0d", base + p), rd_data[p*W +: W], '0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
